// File: rtl/complete_arbiter_pkg.sv
// Shared definitions for the completion arbiter.
// Holds the default ROB depth, datapath width and functional-unit count, the
// FU completion record layout and a saturating-increment helper.
package complete_arbiter_pkg;

  localparam int unsigned RobSzDefault = 32;
  localparam int unsigned XlenDefault  = 32;
  localparam int unsigned NFu          = 4;

  localparam int unsigned IdxW = $clog2(RobSzDefault);

  // Completion record handed over by a functional unit.
  typedef struct packed {
    logic [IdxW-1:0]        idx;
    logic [XlenDefault-1:0] result;
    logic [XlenDefault-1:0] rs2_value;
    logic                   take_branch;
  } fu_complete_packet_t;

  // 32-bit increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/complete_arbiter_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// The search for a winner starts at the pointer. After a grant to requester i,
// the pointer moves to (i+1) mod N. When nothing is granted the pointer does
// not move. This block is shared with the issue stage.
// Ports:
//   clock  - system clock
//   reset  - synchronous active-high reset (pointer returns to 0)
//   req    - request vector
//   grant  - one-hot grant, combinational from req and the pointer
module complete_arbiter_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;

  // Scan from ptr_q upward with wrap. The first request seen wins.
  always_comb begin
    logic        found;
    int unsigned j;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!found && req[j[PtrW-1:0]]) begin
        grant[j[PtrW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) ptr_d = (i == N - 1) ? '0 : PtrW'(i + 1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/complete_arbiter.sv
// Completion arbiter: N_REQ functional units share the single ROB completion
// write port.
// Each FU hands a record to its own one-entry slot through a valid/ready
// handshake. Each cycle one occupied slot is granted round-robin. The granted
// record is registered onto the ROB completion fields with a one-cycle strobe.
// Optional feature macro: COMPLETE_ARB_STATS_EN adds per-FU saturating stall
// counters on output stall_cycles.
// Ports:
//   clock, reset        - clock and synchronous active-high reset
//   req_valid/req_ready - per-FU handshake
//   req_idx, req_result, req_rs2_value, req_take_branch - flattened per-FU
//                         payload (FU i at slice i)
//   complete_en, complete_idx, result, rs2_value, take_branch - registered
//                         ROB write port
//   pending             - slot occupancy
//   stall_cycles        - (stats build only) per-FU 32-bit stall counts
module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ  = NFu,
  parameter  int unsigned ROB_SZ = RobSzDefault,
  parameter  int unsigned XLEN   = XlenDefault,
  localparam int unsigned IDXW   = $clog2(ROB_SZ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*IDXW-1:0] req_idx,
  input  logic [N_REQ*XLEN-1:0] req_result,
  input  logic [N_REQ*XLEN-1:0] req_rs2_value,
  input  logic [N_REQ-1:0]      req_take_branch,
  output logic                  complete_en,
  output logic [IDXW-1:0]       complete_idx,
  output logic [XLEN-1:0]       result,
  output logic [XLEN-1:0]       rs2_value,
  output logic                  take_branch,
`ifdef COMPLETE_ARB_STATS_EN
  output logic [N_REQ*32-1:0]   stall_cycles,
`endif
  output logic [N_REQ-1:0]      pending
);

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rs2_value;
    logic            take_branch;
  } slot_t;

  slot_t [N_REQ-1:0] req_pkt;
  slot_t [N_REQ-1:0] slot_q;
  slot_t             sel_pkt;
  slot_t             out_q;
  logic [N_REQ-1:0]  slot_valid_q, slot_valid_d;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  accept;
  logic              complete_en_q;

  complete_arbiter_rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .clock (clock),
    .reset (reset),
    .req   (slot_valid_q),
    .grant (grant)
  );

  // A granted slot drains this edge, so it can take a new record in the same cycle.
  assign req_ready = ~slot_valid_q | grant;
  assign accept    = req_valid & req_ready;
  assign pending   = slot_valid_q;

  // An accept wins over a drain, which lets a slot drain and refill on the same edge.
  assign slot_valid_d = (slot_valid_q & ~grant) | accept;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_pkt[i].idx         = req_idx[i*IDXW +: IDXW];
      req_pkt[i].result      = req_result[i*XLEN +: XLEN];
      req_pkt[i].rs2_value   = req_rs2_value[i*XLEN +: XLEN];
      req_pkt[i].take_branch = req_take_branch[i];
    end
  end

  // The grant is one-hot, so an OR-select is enough.
  always_comb begin
    sel_pkt = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_pkt = sel_pkt | slot_q[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid_q  <= '0;
      slot_q        <= '0;
      complete_en_q <= 1'b0;
      out_q         <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (accept[i]) slot_q[i] <= req_pkt[i];
      end
      complete_en_q <= |grant;
      // When nothing is granted the payload keeps its last value.
      if (|grant) out_q <= sel_pkt;
    end
  end

  assign complete_en  = complete_en_q;
  assign complete_idx = out_q.idx;
  assign result       = out_q.result;
  assign rs2_value    = out_q.rs2_value;
  assign take_branch  = out_q.take_branch;

`ifdef COMPLETE_ARB_STATS_EN
  logic [N_REQ-1:0][31:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && !req_ready[i]) stall_q[i] <= sat_inc(stall_q[i]);
      end
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_complete_arbiter.sv
// Self-checking bench for complete_arbiter. It runs directed scenarios and a
// randomized run, and checks them against a cycle-level reference model.
module tb_complete_arbiter;
  import complete_arbiter_pkg::*;

  localparam int N  = NFu;
  localparam int IW = $clog2(RobSzDefault);
  localparam int XW = XlenDefault;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*IW-1:0]   req_idx;
  logic [N*XW-1:0]   req_result;
  logic [N*XW-1:0]   req_rs2_value;
  logic [N-1:0]      req_take_branch;
  logic              complete_en;
  logic [IW-1:0]     complete_idx;
  logic [XW-1:0]     result;
  logic [XW-1:0]     rs2_value;
  logic              take_branch;
  logic [N-1:0]      pending;
`ifdef COMPLETE_ARB_STATS_EN
  logic [N*32-1:0]   stall_cycles;
`endif

  logic [IW-1:0] d_idx [N];
  logic [XW-1:0] d_res [N];
  logic [XW-1:0] d_rs2 [N];
  logic          d_tb  [N];

  int checks = 0;
  int errors = 0;

  complete_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_idx         (req_idx),
    .req_result      (req_result),
    .req_rs2_value   (req_rs2_value),
    .req_take_branch (req_take_branch),
    .complete_en     (complete_en),
    .complete_idx    (complete_idx),
    .result          (result),
    .rs2_value       (rs2_value),
    .take_branch     (take_branch),
`ifdef COMPLETE_ARB_STATS_EN
    .stall_cycles    (stall_cycles),
`endif
    .pending         (pending)
  );

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_idx[i*IW +: IW]       = d_idx[i];
      req_result[i*XW +: XW]    = d_res[i];
      req_rs2_value[i*XW +: XW] = d_rs2[i];
      req_take_branch[i]        = d_tb[i];
    end
  end

  // Reference model. Each FU owns a mailbox that holds at most one record.
  // Service order is a rotating turn.
  fu_complete_packet_t m_slot [N];
  bit                  m_valid [N];
  int                  m_ptr;
  bit                  m_en;
  fu_complete_packet_t m_out;
  logic [31:0]         m_stall [N];

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      if (m_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g;
    g = m_grant();
    for (int i = 0; i < N; i++) r[i] = !m_valid[i] || (i == g);
    return r;
  endfunction

  function automatic logic [N-1:0] m_pending();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = m_valid[i];
    return p;
  endfunction

  // Advance one clock. The model uses the inputs as they stand before the edge.
  task automatic cycle();
    int g;
    logic [N-1:0] r;
    g = m_grant();
    r = m_ready();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 0;
        m_stall[i] = 0;
      end
      m_ptr = 0;
      m_en  = 0;
      m_out = '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (req_valid[i] && !r[i] && m_stall[i] != 32'hFFFF_FFFF) m_stall[i]++;
      if (g >= 0) begin
        m_out      = m_slot[g];
        m_en       = 1;
        m_ptr      = (g + 1) % N;
        m_valid[g] = 0;
      end else begin
        m_en = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && r[i]) begin
          m_valid[i] = 1;
          m_slot[i]  = '{idx: d_idx[i], result: d_res[i], rs2_value: d_rs2[i],
                         take_branch: d_tb[i]};
        end
      end
    end
    #1;
  endtask

  task automatic drive(input int i, input bit v, input int idx, input logic [XW-1:0] res);
    req_valid[i] = v;
    d_idx[i]     = IW'(idx);
    d_res[i]     = res;
    d_rs2[i]     = XW'($urandom);
    d_tb[i]      = 1'($urandom);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) drive(i, 1, i, XW'($urandom));
    cycle();
    cycle();
    reset     = 1'b0;
    req_valid = '0;
    checks++;
    if (complete_en !== 1'b0) begin
      errors++; $display("FAIL reset_en got %b exp 0", complete_en);
    end
    checks++;
    if (pending !== '0) begin
      errors++; $display("FAIL reset_pending got %b exp 0", pending);
    end
    checks++;
    if (req_ready !== '1) begin
      errors++; $display("FAIL reset_ready got %b exp all ones", req_ready);
    end
    cycle();
    checks++;
    if (pending !== '0 || complete_en !== 1'b0) begin
      errors++; $display("FAIL reset_idle got pend %b en %b exp 0 0", pending, complete_en);
    end
  endtask

  task automatic test_single();
    logic exp_tb;
    drive(1, 1, 5, 32'hDEAD_BEEF);
    exp_tb = d_tb[1];
    cycle();
    req_valid = '0;
    checks++;
    if (pending !== 4'b0010 || complete_en !== 1'b0) begin
      errors++; $display("FAIL single_e0 got pend %b en %b exp 0010 0", pending, complete_en);
    end
    cycle();
    checks++;
    if (complete_en !== 1'b1 || complete_idx !== IW'(5) || result !== XW'(32'hDEAD_BEEF)
        || take_branch !== exp_tb) begin
      errors++; $display("FAIL single_strobe got en %b idx %0d res %h tb %b exp 1 5 deadbeef %b",
                         complete_en, complete_idx, result, take_branch, exp_tb);
    end
    cycle();
    checks++;
    if (complete_en !== 1'b0) begin
      errors++; $display("FAIL single_once got en %b exp 0", complete_en);
    end
  endtask

  task automatic test_contention();
    logic [XW-1:0] exp_res [N];
    logic [N-1:0]  exp_rdy;
    do_reset();
    for (int i = 0; i < N; i++) begin
      exp_res[i] = XW'($urandom);
      drive(i, 1, i, exp_res[i]);
    end
    cycle();
    req_valid = '0;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL cont_ready0 got %b exp 0001", req_ready);
    end
    for (int k = 0; k < N; k++) begin
      cycle();
      exp_rdy = (k + 2 >= N) ? '1 : N'((1 << (k + 2)) - 1);
      checks++;
      if (complete_en !== 1'b1 || complete_idx !== IW'(k) || result !== exp_res[k]) begin
        errors++; $display("FAIL cont_order%0d got en %b idx %0d res %h exp 1 %0d %h",
                           k, complete_en, complete_idx, result, k, exp_res[k]);
      end
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL cont_ready%0d got %b exp %b", k + 1, req_ready, exp_rdy);
      end
    end
    cycle();
    checks++;
    if (complete_en !== 1'b0) begin
      errors++; $display("FAIL cont_end got en %b exp 0", complete_en);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(2, 1, 7, XW'($urandom));
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    drive(0, 1, 20, XW'($urandom));
    drive(3, 1, 23, XW'($urandom));
    cycle();
    req_valid = '0;
    cycle();
    checks++;
    if (complete_en !== 1'b1 || complete_idx !== IW'(23)) begin
      errors++; $display("FAIL wrap_first got en %b idx %0d exp 1 23", complete_en, complete_idx);
    end
    cycle();
    checks++;
    if (complete_en !== 1'b1 || complete_idx !== IW'(20)) begin
      errors++; $display("FAIL wrap_second got en %b idx %0d exp 1 20", complete_en, complete_idx);
    end
    // With the turn now at FU1, FU1 wins over FU0.
    drive(0, 1, 30, XW'($urandom));
    drive(1, 1, 31, XW'($urandom));
    cycle();
    req_valid = '0;
    cycle();
    checks++;
    if (complete_en !== 1'b1 || complete_idx !== IW'(31)) begin
      errors++; $display("FAIL wrap_ptr got en %b idx %0d exp 1 31", complete_en, complete_idx);
    end
    cycle();
    checks++;
    if (complete_en !== 1'b1 || complete_idx !== IW'(30)) begin
      errors++; $display("FAIL wrap_ptr2 got en %b idx %0d exp 1 30", complete_en, complete_idx);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      drive(2, 1, 8 + r, XW'($urandom));
      checks++;
      if (req_ready[2] !== 1'b1) begin
        errors++; $display("FAIL b2b_ready%0d got %b exp 1", r, req_ready[2]);
      end
      cycle();
      if (r > 0) begin
        checks++;
        if (complete_en !== 1'b1 || complete_idx !== IW'(7 + r)) begin
          errors++; $display("FAIL b2b_pulse%0d got en %b idx %0d exp 1 %0d",
                             r, complete_en, complete_idx, 7 + r);
        end
      end
    end
    req_valid = '0;
    cycle();
    checks++;
    if (complete_en !== 1'b1 || complete_idx !== IW'(11)) begin
      errors++; $display("FAIL b2b_last got en %b idx %0d exp 1 11", complete_en, complete_idx);
    end
    cycle();
    checks++;
    if (complete_en !== 1'b0) begin
      errors++; $display("FAIL b2b_end got en %b exp 0", complete_en);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rdy = m_ready();
      for (int i = 0; i < N; i++) begin
        // A stalled FU keeps its record stable until it is accepted.
        if (!(req_valid[i] && !rdy[i])) begin
          drive(i, ($urandom_range(0, 99) < 60), $urandom, XW'($urandom));
        end
      end
      checks++;
      if (req_ready !== rdy || pending !== m_pending()) begin
        errors++; $display("FAIL rand_ready c%0d got rdy %b pend %b exp %b %b",
                           c, req_ready, pending, rdy, m_pending());
      end
      cycle();
      checks++;
      if (complete_en !== m_en) begin
        errors++; $display("FAIL rand_en c%0d got %b exp %b", c, complete_en, m_en);
      end else if (m_en && (complete_idx !== m_out.idx || result !== m_out.result ||
                            rs2_value !== m_out.rs2_value || take_branch !== m_out.take_branch)) begin
        errors++; $display("FAIL rand_data c%0d got %0d %h %h %b exp %0d %h %h %b", c,
                           complete_idx, result, rs2_value, take_branch, m_out.idx,
                           m_out.result, m_out.rs2_value, m_out.take_branch);
      end
    end
    req_valid = '0;
`ifdef COMPLETE_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      checks++;
      if (stall_cycles[i*32 +: 32] !== m_stall[i]) begin
        errors++; $display("FAIL rand_stall%0d got %0d exp %0d",
                           i, stall_cycles[i*32 +: 32], m_stall[i]);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 1, 1, XW'($urandom));
    drive(1, 1, 2, XW'($urandom));
    drive(3, 1, 3, XW'($urandom));
    cycle();
    req_valid    = '0;
    req_valid[1] = 1'b1;
    cycle();
    checks++;
    if (pending !== m_pending()) begin
      errors++; $display("FAIL mid_fill got %b exp %b", pending, m_pending());
    end
    reset = 1'b1;
    cycle();
    reset     = 1'b0;
    req_valid = '0;
    checks++;
    if (pending !== '0 || complete_en !== 1'b0) begin
      errors++; $display("FAIL mid_reset got pend %b en %b exp 0 0", pending, complete_en);
    end
`ifdef COMPLETE_ARB_STATS_EN
    checks++;
    if (stall_cycles !== '0) begin
      errors++; $display("FAIL mid_stall got %h exp 0", stall_cycles);
    end
`endif
    for (int c = 0; c < 4; c++) begin
      cycle();
      checks++;
      if (complete_en !== 1'b0) begin
        errors++; $display("FAIL mid_quiet%0d got en %b exp 0", c, complete_en);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      d_idx[i] = '0;
      d_res[i] = '0;
      d_rs2[i] = '0;
      d_tb[i]  = 1'b0;
    end
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
